// File: rtl/booth_seq_mul.sv
// booth_seq_mul: iterative radix-4 Booth multiplier, one Booth digit per cycle, valid/ready on both sides
module booth_pp #(
  parameter int W    = 16,
  parameter int PIPE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   digit,
  input  logic [W-1:0] y,
  output logic [W:0]   pp,
  output logic         cpl
);
  logic [W:0] mag, pp_c;
  always_comb begin
    mag  = (digit == 3'b011 || digit == 3'b100) ? {y, 1'b0} :
           (digit == 3'b000 || digit == 3'b111) ? '0 : {y[W-1], y};
    pp_c = digit[2] ? ~mag : mag;
  end
  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        pp  <= '0;
        cpl <= 1'b0;
      end else begin
        pp  <= pp_c;
        cpl <= digit[2];
      end
  end else begin : g_comb
    assign pp  = pp_c;
    assign cpl = digit[2];
  end
endmodule

module booth_seq_mul #(
  parameter int W       = 16,
  parameter int PP_PIPE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);
  localparam int CW   = $clog2(W/2 + 1) + 1;
  localparam int LAST = W/2 - 1 + PP_PIPE;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state;
  logic [W:0]     a_sh;
  logic [W-1:0]   b_reg;
  logic [CW-1:0]  cnt, k;
  logic [2*W-1:0] acc, pp_ext, term;
  logic [W:0]     pp;
  logic           cpl, consume;
  booth_pp #(.W(W), .PIPE(PP_PIPE)) u_pp (
    .clk(clk), .rst(rst), .digit(a_sh[2:0]), .y(b_reg), .pp(pp), .cpl(cpl)
  );
  // with a registered pp stage the consumed digit trails the issued one by a cycle
  always_comb begin
    k       = cnt - CW'(PP_PIPE);
    consume = (PP_PIPE == 0) || (cnt != '0);
    pp_ext  = {{(W-1){pp[W]}}, pp};
    term    = (pp_ext + {{(2*W-1){1'b0}}, cpl}) << {k, 1'b0};
  end
  assign product = acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      a_sh      <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh     <= {a, 1'b0};
          b_reg    <= b;
          acc      <= '0;
          cnt      <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          a_sh <= a_sh >> 2;
          cnt  <= cnt + 1'b1;
          if (consume) acc <= acc + term;
          if (cnt == CW'(LAST)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: scoreboard bench running both PP_PIPE variants side by side against a signed-multiply model
module tb_booth_seq_mul;
  localparam int W = 16;
  logic clk = 1'b0;
  int   total = 0, passed = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic tmo(input string nm);
    total++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic logic [W-1:0] rnd();
    int s = $urandom % 8;
    logic [W-1:0] v = W'($urandom);
    return s == 0 ? {1'b1, {(W-1){1'b0}}} : s == 1 ? '0 : s == 2 ? {1'b0, {(W-1){1'b1}}} : s == 3 ? '1 : v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    logic           rst, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] product, hold;
    logic [2*W-1:0] exp_q[$];
    int             t_q[$];
    int             cyc = 0;
    bit             seen = 0;

    booth_seq_mul #(.W(W), .PP_PIPE(g)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
      if (!rst && in_valid && in_ready) begin
        exp_q.push_back($signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}));
        t_q.push_back(cyc);
      end
      if (!rst && out_valid && !seen) begin
        seen = 1;
        if (t_q.size() == 0) chk("latency_queue", 64'(t_q.size()), 64'd1);
        else chk($sformatf("latency_pipe%0d", g), 64'(cyc - t_q.pop_front()), 64'(W/2 + 1 + g));
      end
      if (!rst && out_valid && out_ready) begin
        seen = 0;
        if (exp_q.size() == 0) chk("spurious_out", 64'(exp_q.size()), 64'd1);
        else chk($sformatf("product_pipe%0d", g), 64'(product), 64'(exp_q.pop_front()));
      end
    end

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      @(posedge clk); #1;
      a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) tmo("accept");
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 400) begin @(posedge clk); #2; n++; end
      if (n >= 400) tmo("idle");
    endtask

    task automatic wait_ov();
      int n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #2; n++; end
      if (n >= 50) tmo("out_valid");
    endtask

    initial begin
      bit stop = 0;
      done = 0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_product", 64'(product), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      op(16'd3, 16'd5); wait_idle();
      op(16'h8000, 16'h8000);
      op(16'hFFFF, 16'd1);
      op(16'h7FFF, 16'h8000);
      op(16'd0, 16'h1234);
      op(16'h1234, 16'd0);
      wait_idle();
      // stalled consumer: product and flags must freeze, new operands ignored
      out_ready = 1'b0;
      op(16'd1234, -16'sd77);
      wait_ov();
      hold = product;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        in_valid = 1'b1; a = rnd(); b = rnd();
        @(negedge clk);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_product", 64'(product), 64'(hold));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_out_valid", 64'(out_valid), 64'd0);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      // reset while digit 4 is in flight
      op(16'd100, 16'd200);
      repeat (3) @(posedge clk);
      #1 chk("mid_run_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      exp_q.delete(); t_q.delete(); seen = 0;
      chk("abort_product", 64'(product), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1 rst = 1'b0;
      op(16'd7, -16'sd6); wait_idle();
      // back-to-back with in_valid and out_ready held high
      @(posedge clk); #1;
      a = rnd(); b = rnd(); in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) tmo("b2b_accept");
        @(posedge clk); #1;
        a = rnd(); b = rnd();
      end
      in_valid = 1'b0;
      wait_idle();
      fork
        begin
          for (int i = 0; i < 2000; i++) op(rnd(), rnd());
          stop = 1;
        end
        while (!stop) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
        end
      join
      out_ready = 1'b1;
      wait_idle();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      done = 1;
    end
  end

  initial begin
    fork
      wait (lane[0].done && lane[1].done);
      begin
        #3000000;
        $display("FAIL global_timeout: lanes did not complete");
        $fatal(1);
      end
    join_any
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
